power_key_ctrl: RTL and testbench

//  Receiving end of the raw power-button interface driven into top. Synchronises and debounces
//  on_off_btn, turns a short press into power-on and a long hold into power-off, and presents

---
 rtl/power_key_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_power_key_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_key_ctrl.sv
// power_key_ctrl: receiving end of the raw power button. Synchronises and
// debounces the buttons, turns a short press into power-on and a long hold into
// power-off, and publishes machine_state plus one-cycle on/off strobes.
// Optional feature macro: POWER_GESTURE_EN adds debouncers on left_btn/right_btn
// and a left->right (power on) / right->left (power off) gesture sequencer.
module power_key_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd1_000_000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd300_000_000,
  parameter logic [31:0] GESTURE_WINDOW    = 32'd500_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic on_off_btn,
  input  logic left_btn,
  input  logic right_btn,
  output logic machine_state,
  output logic power_on_pulse,
  output logic power_off_pulse
);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ON       = 2'd1,
    OFF_LOCK = 2'd2
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 20'd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 32'd1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

`ifdef POWER_GESTURE_EN
  // Button index 0 = on_off, 1 = left, 2 = right
  localparam int NB = 3;
  localparam int WW = $clog2(GESTURE_WINDOW) + 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(GESTURE_WINDOW - 32'd1);
`else
  localparam int NB = 1;
`endif

  logic [NB-1:0] raw;
  logic [NB-1:0] rise;
  logic          on_level;
  logic          on_sampled;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          press_ok;
  logic          hold_hit;
  logic          gest_fire;
  logic          power_up;
  logic          power_down_lock;
  logic          power_down_gest;

`ifdef POWER_GESTURE_EN
  logic          gest_armed;
  logic [WW-1:0] win_cnt;
  logic          arm_rise;
  logic          done_rise;

  assign raw = {right_btn, left_btn, on_off_btn};
`else
  logic unused_side;

  assign raw         = on_off_btn;
  assign unused_side = ^{left_btn, right_btn, GESTURE_WINDOW};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic          s1;
      logic          s2;
      logic          lvl;
      logic          lvl_d;
      logic [DW-1:0] cnt;

      // Two-flop synchroniser, left out of reset so it keeps tracking the pin
      always_ff @(posedge clk) begin
        s1 <= raw[gi];
        s2 <= s1;
      end

      // Debouncer: flip the accepted level after DEBOUNCE_CYCLES differing samples
      always_ff @(posedge clk) begin
        if (reset) begin
          lvl   <= 1'b0;
          lvl_d <= 1'b0;
          cnt   <= '0;
        end else begin
          lvl_d <= lvl;
          if (s2 == lvl) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            lvl <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
      end

      assign rise[gi] = lvl & ~lvl_d;
    end
  endgenerate

  assign on_level   = g_btn[0].lvl;
  assign on_sampled = g_btn[0].s2;

`ifdef POWER_GESTURE_EN
  // The arming button is left while off and right while on; the other one completes
  assign arm_rise  = (state == ON) ? rise[2] : rise[1];
  assign done_rise = (state == ON) ? rise[1] : rise[2];
  assign gest_fire = gest_armed && done_rise && !arm_rise && (state != OFF_LOCK);
`else
  assign gest_fire = 1'b0;
`endif

  // press_ok blocks a button still held across reset from powering on
  assign hold_hit        = on_level && (hold_cnt == HOLD_LAST);
  assign power_up        = (state == OFF) && ((rise[0] && press_ok) || gest_fire);
  assign power_down_lock = (state == ON) && hold_hit;
  assign power_down_gest = (state == ON) && !hold_hit && gest_fire;

  // Power FSM with registered outputs, hold timer and gesture window
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= OFF;
      machine_state   <= 1'b0;
      power_on_pulse  <= 1'b0;
      power_off_pulse <= 1'b0;
      hold_cnt        <= '0;
      press_ok        <= 1'b0;
`ifdef POWER_GESTURE_EN
      gest_armed      <= 1'b0;
      win_cnt         <= '0;
`endif
    end else begin
      power_on_pulse  <= 1'b0;
      power_off_pulse <= 1'b0;

      if (!on_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      if (!on_sampled) begin
        press_ok <= 1'b1;
      end

`ifdef POWER_GESTURE_EN
      if (power_up || power_down_lock || power_down_gest || (state == OFF_LOCK) ||
          (arm_rise && done_rise)) begin
        gest_armed <= 1'b0;
      end else if (arm_rise) begin
        gest_armed <= 1'b1;
        win_cnt    <= '0;
      end else if (gest_armed) begin
        if (win_cnt == WIN_LAST) begin
          gest_armed <= 1'b0;
        end else begin
          win_cnt <= win_cnt + WW'(1);
        end
      end
`endif

      case (state)
        OFF: begin
          if (power_up) begin
            state          <= ON;
            machine_state  <= 1'b1;
            power_on_pulse <= 1'b1;
          end
        end
        ON: begin
          if (power_down_lock) begin
            state           <= OFF_LOCK;
            machine_state   <= 1'b0;
            power_off_pulse <= 1'b1;
          end else if (power_down_gest) begin
            state           <= OFF;
            machine_state   <= 1'b0;
            power_off_pulse <= 1'b1;
          end
        end
        OFF_LOCK: begin
          if (!on_level) begin
            state <= OFF;
          end
        end
        default: begin
          state         <= OFF;
          machine_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_key_ctrl.sv
// tb_power_key_ctrl: directed bench for power_key_ctrl with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, GESTURE_WINDOW=30. Each cycle compares
// {machine_state, power_on_pulse, power_off_pulse} against a hand-derived value.
// Timing used throughout: button driven just after edge t -> accepted at t+6,
// power-on at t+7, long-hold power-off at t+26.
module tb_power_key_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic on_off_btn = 1'b0;
  logic left_btn = 1'b0;
  logic right_btn = 1'b0;
  logic machine_state;
  logic power_on_pulse;
  logic power_off_pulse;

  int compared = 0;
  int mismatched = 0;

  logic [2:0] obs;
  logic [2:0] want;

  always #5 clk = ~clk;

  power_key_ctrl #(
    .DEBOUNCE_CYCLES  (20'd4),
    .LONG_PRESS_CYCLES(32'd20),
    .GESTURE_WINDOW   (32'd30)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .on_off_btn     (on_off_btn),
    .left_btn       (left_btn),
    .right_btn      (right_btn),
    .machine_state  (machine_state),
    .power_on_pulse (power_on_pulse),
    .power_off_pulse(power_off_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs = {machine_state, power_on_pulse, power_off_pulse};
    compared++;
    if (obs !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_state: got %b want 000", obs);
    end
    for (int i = 1; i <= 50; i++) begin
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b000) begin
        mismatched++;
        $display("FAIL reset_idle cycle %0d: got %b want 000", i, obs);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_short_press();
    on_off_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i >= 7), (i == 7), 1'b0};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL short_press cycle %0d: got %b want %b", i, obs, want);
      end
    end
    on_off_btn = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b100) begin
        mismatched++;
        $display("FAIL short_release cycle %0d: got %b want 100", i, obs);
      end
    end
    $display("test_short_press done");
  endtask

  task automatic test_glitch_and_long_hold();
    on_off_btn = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      if (i == 4) on_off_btn = 1'b0;
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b100) begin
        mismatched++;
        $display("FAIL glitch cycle %0d: got %b want 100", i, obs);
      end
    end
    on_off_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i < 26), 1'b0, (i == 26)};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL long_hold cycle %0d: got %b want %b", i, obs, want);
      end
    end
    on_off_btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b000) begin
        mismatched++;
        $display("FAIL lock_release cycle %0d: got %b want 000", i, obs);
      end
    end
    // New press powers on, and keeping it held powers off again
    on_off_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i >= 7 && i < 26), (i == 7), (i == 26)};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL repress cycle %0d: got %b want %b", i, obs, want);
      end
    end
    on_off_btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b000) begin
        mismatched++;
        $display("FAIL repress_release cycle %0d: got %b want 000", i, obs);
      end
    end
    $display("test_glitch_and_long_hold done");
  endtask

  task automatic test_back_to_back();
    int on_cnt = 0;
    int off_cnt = 0;
    logic last_on = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      int phase = c / 57;
      int k = c % 57 + 1;
      logic pressing = (phase % 2) == 0;
      if (c % 57 == 0) on_off_btn = pressing;
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {pressing && k >= 7 && k < 26, pressing && k == 7, pressing && k == 26};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL toggle cycle %0d: got %b want %b", c, obs, want);
      end
      compared++;
      if ((power_on_pulse & power_off_pulse) !== 1'b0) begin
        mismatched++;
        $display("FAIL pulse_overlap cycle %0d: got on=%b off=%b want not both", c,
                 power_on_pulse, power_off_pulse);
      end
      if (power_on_pulse === 1'b1) begin
        on_cnt++;
        compared++;
        if (last_on !== 1'b0) begin
          mismatched++;
          $display("FAIL alternate cycle %0d: got two on pulses, want off between", c);
        end
        last_on = 1'b1;
      end
      if (power_off_pulse === 1'b1) begin
        off_cnt++;
        compared++;
        if (last_on !== 1'b1) begin
          mismatched++;
          $display("FAIL alternate cycle %0d: got two off pulses, want on between", c);
        end
        last_on = 1'b0;
      end
    end
    on_off_btn = 1'b0;
    compared++;
    if (on_cnt !== 9 || off_cnt !== 9) begin
      mismatched++;
      $display("FAIL toggle_counts: got on=%0d off=%0d want on=9 off=9", on_cnt, off_cnt);
    end
    for (int i = 1; i <= 20; i++) tick();
    $display("test_back_to_back done: %0d on / %0d off pulses", on_cnt, off_cnt);
  endtask

  task automatic test_reset_mid_hold();
    on_off_btn = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i >= 7), (i == 7), 1'b0};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL mid_hold cycle %0d: got %b want %b", i, obs, want);
      end
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs = {machine_state, power_on_pulse, power_off_pulse};
    compared++;
    if (obs !== 3'b000) begin
      mismatched++;
      $display("FAIL mid_hold_reset: got %b want 000", obs);
    end
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) on_off_btn = 1'b0;
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b000) begin
        mismatched++;
        $display("FAIL held_after_reset cycle %0d: got %b want 000", i, obs);
      end
    end
    on_off_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i >= 7 && i < 26), (i == 7), (i == 26)};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL press_after_reset cycle %0d: got %b want %b", i, obs, want);
      end
    end
    on_off_btn = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    $display("test_reset_mid_hold done");
  endtask

`ifdef POWER_GESTURE_EN
  task automatic test_gesture();
    left_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) begin
        left_btn  = 1'b0;
        right_btn = 1'b1;
      end
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i >= 17), (i == 17), 1'b0};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL gesture_on cycle %0d: got %b want %b", i, obs, want);
      end
    end
    right_btn = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    // Right then left 40 cycles later: window expires, no change
    right_btn = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      if (i == 6) right_btn = 1'b0;
      if (i == 41) left_btn = 1'b1;
      if (i == 51) left_btn = 1'b0;
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b100) begin
        mismatched++;
        $display("FAIL gesture_expired cycle %0d: got %b want 100", i, obs);
      end
    end
    right_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) begin
        right_btn = 1'b0;
        left_btn  = 1'b1;
      end
      if (i == 21) left_btn = 1'b0;
      tick();
      obs  = {machine_state, power_on_pulse, power_off_pulse};
      want = {(i < 17), 1'b0, (i == 17)};
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL gesture_off cycle %0d: got %b want %b", i, obs, want);
      end
    end
    $display("test_gesture done");
  endtask
`else
  task automatic test_side_buttons_ignored();
    left_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) begin
        left_btn  = 1'b0;
        right_btn = 1'b1;
      end
      if (i == 21) right_btn = 1'b0;
      tick();
      obs = {machine_state, power_on_pulse, power_off_pulse};
      compared++;
      if (obs !== 3'b000) begin
        mismatched++;
        $display("FAIL side_ignored cycle %0d: got %b want 000", i, obs);
      end
    end
    $display("test_side_buttons_ignored done");
  endtask
`endif

  initial begin
    test_reset();
    test_short_press();
    test_glitch_and_long_hold();
    test_back_to_back();
    test_reset_mid_hold();
`ifdef POWER_GESTURE_EN
    test_gesture();
`else
    test_side_buttons_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
